id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register with operand forwarding and load-use hazard detection.
- Sits directly upstream of alu. Its A, B and ALUSel outputs connect straight to alu.A, alu.B and alu.ALUSel.
- Captures decoded fields every cycle and resolves RAW hazards against the EX/MEM and MEM/WB stages.
- Requests a one-cycle decode stall on a load-use dependency.

Parameters:
- XLEN, 32, datapath width.
- RAW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low; all state cleared on assertion.
- d_valid  in  1  decode holds a valid instruction.
- d_pc  in  XLEN  instruction PC.
- d_rs1, d_rs2  in  RAW  source register addresses.
- d_use_rs1, d_use_rs2  in  1  instruction reads rs1 / rs2.
- d_rs1_val, d_rs2_val  in  XLEN  register-file read data.
- d_imm  in  XLEN  sign-extended immediate.
- d_asel  in  1  A source: 0 = rs1, 1 = pc.
- d_bsel  in  1  B source: 0 = rs2, 1 = imm.
- d_alusel  in  4  ALU op code.
- d_rd  in  RAW  destination register.
- d_wen  in  1  destination write enable.
- d_mem_read  in  1  instruction is a load.
- stall  in  1  global freeze; EX register holds.
- flush  in  1  kill the instruction entering EX.
- mem_rd  in  RAW  EX/MEM destination register.
- mem_wen  in  1  EX/MEM write enable.
- mem_data  in  XLEN  EX/MEM ALU result.
- wb_rd  in  RAW  MEM/WB destination register.
- wb_wen  in  1  MEM/WB write enable.
- wb_data  in  XLEN  MEM/WB writeback value.
- A, B  out  XLEN  ALU operands after forwarding and source select.
- ALUSel  out  4  registered ALU op code.
- ex_valid  out  1  EX holds a valid instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rd  out  RAW  registered rd.
- ex_wen  out  1  registered write enable, gated by ex_valid.
- ex_mem_read  out  1  registered load flag, gated by ex_valid.
- ex_store_data  out  XLEN  forwarded rs2 value, used as store data.
- hazard_stall  out  1  load-use stall request to fetch/decode.

Behaviour:
- Reset state: every register is 0, so ex_valid=0 and ALUSel=0.
- While ex_valid=0: A, B and ex_store_data read 0, and hazard_stall reads 0.
- Capture priority at each rising clk edge, highest first:
  1. flush: load a bubble (ex_valid=0, ex_wen=0, ex_mem_read=0, ALUSel=0).
  2. stall: hold all registers.
  3. hazard_stall: load a bubble.
  4. Otherwise: capture all d_* fields; ex_valid is set from d_valid.
- hazard_stall is combinational. It is 1 when all of the following hold:
  - d_valid and ex_valid and ex_mem_read are all 1;
  - ex_rd != 0;
  - (d_use_rs1 and d_rs1 == ex_rd) or (d_use_rs2 and d_rs2 == ex_rd).
- hazard_stall is asserted for exactly one cycle per dependency, because the bubble clears ex_mem_read.
- Forwarding is combinational in EX and is evaluated separately for the registered rs1 and rs2.
- Forwarding priority for each operand:
  1. mem_wen=1 and mem_rd == src and src != 0: use mem_data.
  2. Else wb_wen=1 and wb_rd == src and src != 0: use wb_data.
  3. Else: use the registered register-file value.
- Register x0 is never forwarded; its operand is the captured value.
- Operand select:
  - A = asel ? ex_pc : fwd_rs1.
  - B = bsel ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 regardless of bsel.
- Latency: decode fields reach A/B/ALUSel one cycle after capture. Forwarded data reaches the outputs the same cycle (combinational path).
- Simultaneous events:
  - flush with stall: flush wins.
  - flush with hazard_stall: bubble is loaded, and hazard_stall is still driven so decode holds.
- Reset mid-operation: the in-flight instruction is dropped immediately; outputs go to reset values without waiting for a clock edge.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 mid-run with ex_valid=1.
  - Required: ex_valid=0, A=0, B=0, ALUSel=0 immediately; hold those values until the first capture after release.
- Plain capture:
  - Stimulus: d_rs1_val=7, d_rs2_val=9, d_alusel=0, asel=0, bsel=0, no forwarding.
  - Required: next cycle A=7, B=9, ALUSel=0, ex_valid=1.
- Forward priority:
  - Stimulus: EX rs1=5; mem_rd=5, mem_data=0x11, wb_rd=5, wb_data=0x22, both wen=1.
  - Required: A=0x11.
  - Stimulus change: drop mem_wen.
  - Required: A=0x22.
  - Stimulus change: set rs1=0.
  - Required: A = captured value, no forwarding.
- Load-use:
  - Stimulus: EX holds a load with rd=3; decode has d_use_rs2=1, d_rs2=3.
  - Required: hazard_stall=1 for one cycle, a bubble enters EX, then the dependent instruction is captured.
  - Stimulus variant: same with rd=0.
  - Required: no stall.
- Stall/flush:
  - Stimulus: stall=1 for 3 cycles.
  - Required: A, B and ALUSel remain stable.
  - Stimulus: flush and stall asserted together.
  - Required: ex_valid=0 on the next edge.
- Source select:
  - Stimulus: asel=1, bsel=1, pc=0x100, imm=0xFFFFFFFC.
  - Required: A=0x100, B=0xFFFFFFFC, ex_store_data = forwarded rs2.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, forwards operands from
// EX/MEM and MEM/WB, and requests a one-cycle decode stall on load-use.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            d_valid,
    input  logic [XLEN-1:0] d_pc,
    input  logic [RAW-1:0]  d_rs1,
    input  logic [RAW-1:0]  d_rs2,
    input  logic            d_use_rs1,
    input  logic            d_use_rs2,
    input  logic [XLEN-1:0] d_rs1_val,
    input  logic [XLEN-1:0] d_rs2_val,
    input  logic [XLEN-1:0] d_imm,
    input  logic            d_asel,
    input  logic            d_bsel,
    input  logic [3:0]      d_alusel,
    input  logic [RAW-1:0]  d_rd,
    input  logic            d_wen,
    input  logic            d_mem_read,
    input  logic            stall,
    input  logic            flush,
    input  logic [RAW-1:0]  mem_rd,
    input  logic            mem_wen,
    input  logic [XLEN-1:0] mem_data,
    input  logic [RAW-1:0]  wb_rd,
    input  logic            wb_wen,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [3:0]      ALUSel,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [RAW-1:0]  ex_rd,
    output logic            ex_wen,
    output logic            ex_mem_read,
    output logic [XLEN-1:0] ex_store_data,
    output logic            hazard_stall
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [RAW-1:0]  rs1_q;
    logic [RAW-1:0]  rs2_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [XLEN-1:0] rs2_val_q;
    logic [XLEN-1:0] imm_q;
    logic            asel_q;
    logic            bsel_q;
    logic [3:0]      alusel_q;
    logic [RAW-1:0]  rd_q;
    logic            wen_q;
    logic            mem_read_q;

    logic            load_bubble;
    logic            capture;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    always_comb begin
        hazard_stall = d_valid && valid_q && mem_read_q && (rd_q != '0) &&
                       ((d_use_rs1 && (d_rs1 == rd_q)) ||
                        (d_use_rs2 && (d_rs2 == rd_q)));
    end

    // Flush beats stall; a load-use bubble only loads when not frozen.
    assign load_bubble = flush || (!stall && hazard_stall);
    assign capture     = !flush && !stall && !hazard_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            alusel_q   <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            mem_read_q <= 1'b0;
        end else if (load_bubble) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            asel_q     <= 1'b0;
            bsel_q     <= 1'b0;
            alusel_q   <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            mem_read_q <= 1'b0;
        end else if (capture) begin
            valid_q    <= d_valid;
            pc_q       <= d_pc;
            rs1_q      <= d_rs1;
            rs2_q      <= d_rs2;
            rs1_val_q  <= d_rs1_val;
            rs2_val_q  <= d_rs2_val;
            imm_q      <= d_imm;
            asel_q     <= d_asel;
            bsel_q     <= d_bsel;
            alusel_q   <= d_alusel;
            rd_q       <= d_rd;
            wen_q      <= d_wen;
            mem_read_q <= d_mem_read;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded.
    always_comb begin
        if (mem_wen && (mem_rd == rs1_q) && (rs1_q != '0))
            fwd_rs1 = mem_data;
        else if (wb_wen && (wb_rd == rs1_q) && (rs1_q != '0))
            fwd_rs1 = wb_data;
        else
            fwd_rs1 = rs1_val_q;

        if (mem_wen && (mem_rd == rs2_q) && (rs2_q != '0))
            fwd_rs2 = mem_data;
        else if (wb_wen && (wb_rd == rs2_q) && (rs2_q != '0))
            fwd_rs2 = wb_data;
        else
            fwd_rs2 = rs2_val_q;
    end

    always_comb begin
        A             = '0;
        B             = '0;
        ex_store_data = '0;
        if (valid_q) begin
            A             = asel_q ? pc_q : fwd_rs1;
            B             = bsel_q ? imm_q : fwd_rs2;
            ex_store_data = fwd_rs2;
        end
    end

    assign ALUSel      = alusel_q;
    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rd       = rd_q;
    assign ex_wen      = wen_q && valid_q;
    assign ex_mem_read = mem_read_q && valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX outputs are queued as stimulus
// is driven and popped/compared when the stage presents them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [4:0]  d_rs1, d_rs2;
    logic        d_use_rs1, d_use_rs2;
    logic [31:0] d_rs1_val, d_rs2_val, d_imm;
    logic        d_asel, d_bsel;
    logic [3:0]  d_alusel;
    logic [4:0]  d_rd;
    logic        d_wen, d_mem_read;
    logic        stall, flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_wen, wb_wen;
    logic [31:0] mem_data, wb_data;
    logic [31:0] A, B, ex_pc, ex_store_data;
    logic [3:0]  ALUSel;
    logic        ex_valid, ex_wen, ex_mem_read, hazard_stall;
    logic [4:0]  ex_rd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alusel;
        logic [31:0] sd;
        logic        wen;
        logic        mr;
    } exp_t;

    exp_t sb[$];

    id_ex_stage #(.XLEN(32), .RAW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_pc(d_pc), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val), .d_imm(d_imm),
        .d_asel(d_asel), .d_bsel(d_bsel), .d_alusel(d_alusel),
        .d_rd(d_rd), .d_wen(d_wen), .d_mem_read(d_mem_read),
        .stall(stall), .flush(flush),
        .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .A(A), .B(B), .ALUSel(ALUSel), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_mem_read(ex_mem_read),
        .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic valid, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] alusel,
                              input logic [31:0] sd, input logic wen, input logic mr);
        exp_t e;
        e.tag = tag; e.valid = valid; e.a = a; e.b = b; e.alusel = alusel;
        e.sd = sd; e.wen = wen; e.mr = mr;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".valid"},  {31'd0, ex_valid},    {31'd0, e.valid});
        chk({e.tag, ".A"},      A,                    e.a);
        chk({e.tag, ".B"},      B,                    e.b);
        chk({e.tag, ".ALUSel"}, {28'd0, ALUSel},      {28'd0, e.alusel});
        chk({e.tag, ".sd"},     ex_store_data,        e.sd);
        chk({e.tag, ".wen"},    {31'd0, ex_wen},      {31'd0, e.wen});
        chk({e.tag, ".mr"},     {31'd0, ex_mem_read}, {31'd0, e.mr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic u1, input logic [31:0] v1,
                           input logic [4:0] rs2, input logic u2, input logic [31:0] v2,
                           input logic [31:0] imm, input logic as, input logic bs,
                           input logic [3:0] op, input logic [4:0] rd,
                           input logic wen, input logic mr);
        d_valid = v; d_pc = pc;
        d_rs1 = rs1; d_use_rs1 = u1; d_rs1_val = v1;
        d_rs2 = rs2; d_use_rs2 = u2; d_rs2_val = v2;
        d_imm = imm; d_asel = as; d_bsel = bs; d_alusel = op;
        d_rd = rd; d_wen = wen; d_mem_read = mr;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_rd = '0; mem_wen = 1'b0; mem_data = '0;
        wb_rd = '0; wb_wen = 1'b0; wb_data = '0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        chk("reset.hazard", {31'd0, hazard_stall}, 32'd0);
        rst_n = 1'b1;

        // Plain capture
        set_dec(1, 32'h40, 5'd1, 1, 32'd7, 5'd2, 1, 32'd9, 0, 0, 0, 4'd0, 5'd4, 1, 0);
        tick();
        expect_out("plain", 1, 32'd7, 32'd9, 4'd0, 32'd9, 1, 0);
        check_out();

        // Forwarding: EX/MEM beats MEM/WB
        set_dec(1, 32'h44, 5'd5, 1, 32'h55, 5'd6, 1, 32'h66, 0, 0, 0, 4'd3, 5'd9, 0, 0);
        mem_rd = 5'd5; mem_wen = 1'b1; mem_data = 32'h11;
        wb_rd = 5'd5; wb_wen = 1'b1; wb_data = 32'h22;
        tick();
        expect_out("fwd_mem", 1, 32'h11, 32'h66, 4'd3, 32'h66, 0, 0);
        check_out();
        stall = 1'b1;
        mem_wen = 1'b0;
        #1;
        expect_out("fwd_wb", 1, 32'h22, 32'h66, 4'd3, 32'h66, 0, 0);
        check_out();

        // x0 source is never forwarded
        stall = 1'b0;
        set_dec(1, 32'h48, 5'd0, 1, 32'h77, 5'd6, 1, 32'h66, 0, 0, 0, 4'd3, 5'd9, 0, 0);
        mem_rd = 5'd0; mem_wen = 1'b1; wb_rd = 5'd0; wb_wen = 1'b1;
        tick();
        expect_out("fwd_x0", 1, 32'h77, 32'h66, 4'd3, 32'h66, 0, 0);
        check_out();
        mem_wen = 1'b0; wb_wen = 1'b0;

        // Stall holds EX for three cycles while decode changes
        set_dec(1, 32'h4c, 5'd1, 1, 32'h123, 5'd2, 1, 32'h456, 0, 0, 0, 4'd5, 5'd4, 1, 0);
        tick();
        expect_out("pre_stall", 1, 32'h123, 32'h456, 4'd5, 32'h456, 1, 0);
        check_out();
        stall = 1'b1;
        set_dec(1, 32'h50, 5'd7, 1, 32'hdead, 5'd8, 1, 32'hbeef, 0, 0, 0, 4'd9, 5'd10, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall_hold", 1, 32'h123, 32'h456, 4'd5, 32'h456, 1, 0);
            check_out();
        end
        stall = 1'b0;

        // Load-use on rs2: one stall cycle, a bubble, then capture
        set_dec(1, 32'h54, 5'd1, 1, 32'h10, 5'd0, 0, 32'd0, 0, 0, 0, 4'd0, 5'd3, 1, 1);
        tick();
        expect_out("load", 1, 32'h10, 32'd0, 4'd0, 32'd0, 1, 1);
        check_out();
        set_dec(1, 32'h58, 5'd2, 1, 32'h20, 5'd3, 1, 32'h99, 0, 0, 0, 4'd2, 5'd7, 1, 0);
        #1;
        chk("loaduse.hazard", {31'd0, hazard_stall}, 32'd1);
        tick();
        expect_out("loaduse.bubble", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        chk("loaduse.hazard_clear", {31'd0, hazard_stall}, 32'd0);
        tick();
        expect_out("loaduse.dep", 1, 32'h20, 32'h99, 4'd2, 32'h99, 1, 0);
        check_out();

        // Load to x0 never stalls
        set_dec(1, 32'h5c, 5'd1, 1, 32'h10, 5'd0, 0, 32'd0, 0, 0, 0, 4'd0, 5'd0, 1, 1);
        tick();
        expect_out("load_x0", 1, 32'h10, 32'd0, 4'd0, 32'd0, 1, 1);
        check_out();
        set_dec(1, 32'h60, 5'd2, 1, 32'h21, 5'd0, 1, 32'h5, 0, 0, 0, 4'd4, 5'd7, 1, 0);
        #1;
        chk("x0.hazard", {31'd0, hazard_stall}, 32'd0);
        tick();
        expect_out("x0.dep", 1, 32'h21, 32'h5, 4'd4, 32'h5, 1, 0);
        check_out();

        // Flush alongside a load-use hazard: bubble, hazard still driven
        set_dec(1, 32'h64, 5'd1, 1, 32'h10, 5'd0, 0, 32'd0, 0, 0, 0, 4'd0, 5'd3, 1, 1);
        tick();
        expect_out("load2", 1, 32'h10, 32'd0, 4'd0, 32'd0, 1, 1);
        check_out();
        set_dec(1, 32'h68, 5'd3, 1, 32'h31, 5'd2, 0, 32'h32, 0, 0, 0, 4'd6, 5'd8, 1, 0);
        flush = 1'b1;
        #1;
        chk("flush.hazard", {31'd0, hazard_stall}, 32'd1);
        tick();
        expect_out("flush_hz.bubble", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        flush = 1'b0;
        tick();
        expect_out("after_flush", 1, 32'h31, 32'h32, 4'd6, 32'h32, 1, 0);
        check_out();

        // Flush wins over stall
        flush = 1'b1; stall = 1'b1;
        tick();
        expect_out("flush_stall", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        flush = 1'b0; stall = 1'b0;

        // Source select: pc / imm, store data still the forwarded rs2
        set_dec(1, 32'h100, 5'd1, 0, 32'h1, 5'd8, 1, 32'hab, 32'hfffffffc, 1, 1, 4'd1, 5'd9, 1, 0);
        wb_rd = 5'd8; wb_wen = 1'b1; wb_data = 32'hcd;
        tick();
        expect_out("srcsel", 1, 32'h100, 32'hfffffffc, 4'd1, 32'hcd, 1, 0);
        check_out();

        // Asynchronous reset mid-run, held across edges, then recapture
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("rst_async", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        tick();
        expect_out("rst_hold", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        rst_n = 1'b1;
        #1;
        expect_out("rst_release", 0, 0, 0, 0, 0, 0, 0);
        check_out();
        tick();
        expect_out("rst_recapture", 1, 32'h100, 32'hfffffffc, 4'd1, 32'hcd, 1, 0);
        check_out();

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
